// File: rtl/fft_bitrev_buffer_pkg.sv
// Shared definitions for the FFT input path: frame geometry, sample type and
// the bit-reversal helper used to scatter natural-order samples.
package fft_pkg;

  localparam int DATA_W = 16;
  localparam int N_LOG2 = 8;
  localparam int N      = 1 << N_LOG2;
  localparam int CNT_W  = N_LOG2 + 1;
  localparam int ADDR_W = N_LOG2 + 1;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } cplx_t;

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] x);
    logic [N_LOG2-1:0] r;
    for (int i = 0; i < N_LOG2; i++) r[i] = x[N_LOG2-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_buffer_if.sv
// Sample stream in, frame read port out; the buffer is the slave side.
interface fft_bitrev_buffer_if;
  import fft_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_re;
  logic [DATA_W-1:0] in_im;
  logic              frame_valid;
  logic              rd_en;
  logic [N_LOG2-1:0] rd_addr;
  logic [DATA_W-1:0] rd_re;
  logic [DATA_W-1:0] rd_im;
  logic              rd_valid;
  logic              frame_done;
  logic [CNT_W-1:0]  wr_count;
  logic              overrun;

  modport slave (
    input  in_valid, in_re, in_im, rd_en, rd_addr, frame_done,
    output in_ready, frame_valid, rd_re, rd_im, rd_valid, wr_count, overrun
  );

  modport master (
    output in_valid, in_re, in_im, rd_en, rd_addr, frame_done,
    input  in_ready, frame_valid, rd_re, rd_im, rd_valid, wr_count, overrun
  );

endinterface

// File: rtl/fft_bitrev_buffer_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// No reset on the array or read register so it maps onto block RAM.
module fft_buf_ram
  import fft_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = 2 * DATA_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_bitrev_buffer.sv
// Ping-pong bit-reversing input buffer: natural-order samples in, each frame
// stored at bit-reversed indices, frames read back by the core in natural order.
module fft_bitrev_buffer
  import fft_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  fft_bitrev_buffer_if.slave  bus
);

  logic [1:0]       bank_full_q, bank_full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic             overrun_q, overrun_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_seen_q, rd_seen_d;

  logic             in_ready;
  logic             frame_valid;
  logic             accept;
  logic             last;
  logic             release_rd;
  logic             rd_go;
  cplx_t            wr_word;
  cplx_t            rd_word;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;

  assign in_ready    = !bank_full_q[wr_bank_q];
  assign frame_valid = bank_full_q[rd_bank_q];
  assign accept      = bus.in_valid && in_ready;
  assign last        = accept && (wr_cnt_q == LAST_IDX);
  assign release_rd  = bus.frame_done && frame_valid;
  assign rd_go       = bus.rd_en && frame_valid;

  assign wr_word = '{re: bus.in_re, im: bus.in_im};
  assign waddr   = {wr_bank_q, bitrev(wr_cnt_q[N_LOG2-1:0])};
  // Read address uses the pre-release bank, so a read issued with frame_done
  // still returns data from the frame being released.
  assign raddr   = {rd_bank_q, bus.rd_addr};

  always_comb begin
    bank_full_d = bank_full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_cnt_d    = wr_cnt_q;
    overrun_d   = overrun_q | (bus.in_valid & ~in_ready);
    rd_valid_d  = rd_go;
    rd_seen_d   = rd_seen_q | rd_go;

    if (accept) wr_cnt_d = wr_cnt_q + 1'b1;
    // Fill and release can coincide but never on the same bank: a bank being
    // written is empty, a bank being released is full.
    if (last) begin
      bank_full_d[wr_bank_q] = 1'b1;
      wr_bank_d              = ~wr_bank_q;
      wr_cnt_d               = '0;
    end
    if (release_rd) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d              = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_full_q <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      overrun_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_seen_q   <= 1'b0;
    end else begin
      bank_full_q <= bank_full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      overrun_q   <= overrun_d;
      rd_valid_q  <= rd_valid_d;
      rd_seen_q   <= rd_seen_d;
    end
  end

  fft_buf_ram u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (waddr),
    .wdata (wr_word),
    .re    (rd_go),
    .raddr (raddr),
    .rdata (rd_word)
  );

  // The RAM read register has no reset; mask it to zero until the first
  // read after reset so the outputs come up clean.
  assign bus.rd_re       = rd_seen_q ? rd_word.re : '0;
  assign bus.rd_im       = rd_seen_q ? rd_word.im : '0;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.in_ready    = in_ready;
  assign bus.frame_valid = frame_valid;
  assign bus.wr_count    = wr_cnt_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_fft_bitrev_buffer.sv
// Directed bench for the ping-pong bit-reversing FFT input buffer.
module tb_fft_bitrev_buffer;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  fft_bitrev_buffer_if bus ();

  fft_bitrev_buffer dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] br8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  function automatic logic [31:0] word(input logic [15:0] re);
    logic [15:0] im;
    im = -re;
    return {re, im};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] re);
    bus.in_valid = 1'b1;
    bus.in_re    = re;
    bus.in_im    = -re;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [7:0] a);
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    @(posedge clk); #1;
    bus.rd_en   = 1'b0;
  endtask

  task automatic done_pulse();
    bus.frame_done = 1'b1;
    @(posedge clk); #1;
    bus.frame_done = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] base, input int n);
    for (int k = 0; k < n; k++) send(base + 16'(k));
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_re    = '0;
    bus.in_im    = '0;
    bus.rd_en    = 1'b0;
    bus.rd_addr  = '0;
    bus.frame_done = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",    32'(bus.in_ready),    32'd1);
    chk("rst_frame_valid", 32'(bus.frame_valid), 32'd0);
    chk("rst_rd_valid",    32'(bus.rd_valid),    32'd0);
    chk("rst_overrun",     32'(bus.overrun),     32'd0);
    chk("rst_rd_data",     {bus.rd_re, bus.rd_im}, 32'd0);
    chk("rst_wr_count",    32'(bus.wr_count),    32'd0);
    rst_n = 1'b1;
    idle();

    // Frame 1: re=k, im=-k into bank 0
    send_frame(16'h0000, 255);
    chk("f1_count255", 32'(bus.wr_count),    32'd255);
    chk("f1_fv_early", 32'(bus.frame_valid), 32'd0);
    send(16'd255);
    chk("f1_fv",       32'(bus.frame_valid), 32'd1);
    chk("f1_count0",   32'(bus.wr_count),    32'd0);
    chk("f1_ready",    32'(bus.in_ready),    32'd1);
    rd(8'd1);
    chk("f1_rv",       32'(bus.rd_valid), 32'd1);
    chk("f1_addr1",    {bus.rd_re, bus.rd_im}, word(16'd128));
    rd(8'd3);
    chk("f1_addr3",    {bus.rd_re, bus.rd_im}, word(16'd192));
    rd(8'd255);
    chk("f1_addr255",  {bus.rd_re, bus.rd_im}, word(16'd255));
    idle();
    chk("f1_rv_drop",  32'(bus.rd_valid), 32'd0);

    // Frame 2 fills bank 1 with no release: both full, then overrun
    send_frame(16'h0100, 256);
    chk("f2_ready_low", 32'(bus.in_ready),    32'd0);
    chk("f2_fv",        32'(bus.frame_valid), 32'd1);
    chk("f2_ovr_clear", 32'(bus.overrun),     32'd0);
    send(16'hDEAD);
    chk("ovr_set",      32'(bus.overrun),  32'd1);
    chk("ovr_count0",   32'(bus.wr_count), 32'd0);

    // Read together with frame_done returns the old bank
    bus.rd_en = 1'b1;
    bus.rd_addr = 8'd2;
    bus.frame_done = 1'b1;
    @(posedge clk); #1;
    bus.rd_en = 1'b0;
    bus.frame_done = 1'b0;
    chk("rel_rd_old",   {bus.rd_re, bus.rd_im}, word(16'd64));
    chk("rel_fv_bank1", 32'(bus.frame_valid), 32'd1);
    chk("rel_ready",    32'(bus.in_ready),    32'd1);
    rd(8'd1);
    chk("f2_addr1",     {bus.rd_re, bus.rd_im}, word(16'h0180));

    // Frame 3 completes in the same cycle the core releases bank 1
    send_frame(16'h0200, 255);
    bus.frame_done = 1'b1;
    send(16'h02FF);
    bus.frame_done = 1'b0;
    chk("sim_fv",    32'(bus.frame_valid), 32'd1);
    chk("sim_ready", 32'(bus.in_ready),    32'd1);
    rd(8'd3);
    chk("f3_addr3",  {bus.rd_re, bus.rd_im}, word(16'h02C0));

    // Empty behaviour: ignored read and ignored frame_done
    done_pulse();
    chk("empty_fv", 32'(bus.frame_valid), 32'd0);
    rd(8'd0);
    chk("empty_rv", 32'(bus.rd_valid), 32'd0);
    done_pulse();
    send_frame(16'h0300, 256);
    chk("f4_fv_rdbank_kept", 32'(bus.frame_valid), 32'd1);
    rd(8'd255);
    chk("f4_addr255", {bus.rd_re, bus.rd_im}, word(16'h03FF));
    chk("ovr_sticky", 32'(bus.overrun), 32'd1);

    // Mid-frame reset
    send_frame(16'h0400, 100);
    chk("mid_count100", 32'(bus.wr_count), 32'd100);
    rst_n = 1'b0;
    #1;
    chk("mrst_ready",   32'(bus.in_ready),    32'd1);
    chk("mrst_fv",      32'(bus.frame_valid), 32'd0);
    chk("mrst_rv",      32'(bus.rd_valid),    32'd0);
    chk("mrst_ovr",     32'(bus.overrun),     32'd0);
    chk("mrst_count",   32'(bus.wr_count),    32'd0);
    chk("mrst_rd_data", {bus.rd_re, bus.rd_im}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    idle();

    // Four frames with random input gaps and prompt release
    for (int f = 0; f < 4; f++) begin
      logic [15:0] base;
      base = 16'(f * 16'h1000);
      for (int k = 0; k < 256; k++) begin
        repeat ($urandom_range(0, 1)) idle();
        send(base + 16'(k));
        if (f == 0 && k == 0) chk("post_rst_count1", 32'(bus.wr_count), 32'd1);
      end
      chk($sformatf("rnd%0d_fv", f), 32'(bus.frame_valid), 32'd1);
      for (int a = 0; a < 256; a++) begin
        rd(8'(a));
        chk($sformatf("rnd%0d_a%0d", f, a), {bus.rd_re, bus.rd_im},
            word(base + 16'(br8(8'(a)))));
      end
      done_pulse();
    end
    chk("rnd_no_ovr", 32'(bus.overrun),  32'd0);
    chk("rnd_ready",  32'(bus.in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_buffer.md
# fft_bitrev_buffer

Ping-pong input buffer for the 256-point radix-2 FFT. It accepts natural-order complex samples on a valid/ready stream and writes each one at its bit-reversed index. Completed frames are presented to the butterfly stage, which reads them back in natural address order. It sits directly downstream of the sample source and upstream of the FFT core, and absorbs the bit-reversal that the core expects at its input.

## Interface
- `DATA_W`, 16: width of each of the real and imaginary parts.
- `N_LOG2`, 8: log2 of the frame length. N = 256.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `in_valid` input 1: an input sample is present.
- `in_ready` output 1: the buffer can accept a sample this cycle.
- `in_re`, `in_im` input DATA_W each: input sample.
- `frame_valid` output 1: a complete frame is available to the core.
- `rd_en` input 1: read request from the core.
- `rd_addr` input N_LOG2: natural-order read address.
- `rd_re`, `rd_im` output DATA_W each: read data.
- `rd_valid` output 1: `rd_re`/`rd_im` are valid this cycle.
- `frame_done` input 1: one-cycle pulse from the core; releases the current read bank.
- `wr_count` output N_LOG2+1: number of samples written into the current write bank (0..255).
- `overrun` output 1: sticky flag; `in_valid` was high while `in_ready` was low.

## Operation
- Storage is one 2×N-entry RAM holding 2·DATA_W-bit words. Physical address = {bank, index}, 9 bits.
- State is held in `wr_bank`, `rd_bank`, `bank_full[1:0]` and `wr_cnt`.
- `in_ready = !bank_full[wr_bank]`. A sample is accepted when `in_valid && in_ready`.
- On accept:
  - Write to {wr_bank, bitrev(wr_cnt[7:0])}; bit 0 maps to bit 7, and so on.
  - Then `wr_cnt++`.
- On the accept where `wr_cnt == 255`:
  - `bank_full[wr_bank] <= 1`.
  - `wr_bank` toggles.
  - `wr_cnt <= 0`.
- `frame_valid = bank_full[rd_bank]`.
- Read path:
  - `rd_en` with `frame_valid` high reads {rd_bank, rd_addr}.
  - `rd_en` with `frame_valid` low is ignored and produces no `rd_valid`.
- `frame_done` with `frame_valid` high:
  - `bank_full[rd_bank] <= 0`.
  - `rd_bank` toggles.
  - `frame_done` with `frame_valid` low is ignored.
- Frame completion and `frame_done` in the same cycle always target different banks. Both updates take effect together.
- If the write side fills a bank in the same cycle that the core releases the other bank, `in_ready` is high on the next cycle.
- When both banks are full, `in_ready` is low. `in_valid` during this condition sets `overrun`, and the sample is dropped.
- `overrun` is cleared only by reset.

## Timing
- Reset values:
  - `in_ready` = 1 (both banks empty).
  - `frame_valid`, `rd_valid`, `overrun` = 0.
  - `rd_re`, `rd_im`, `wr_count` = 0.
  - `wr_bank` and `rd_bank` start at 0.
- Reset asserted mid-frame discards all partial and complete frames immediately.
- Write-to-visibility latency: `frame_valid` rises on the cycle after the 256th accept.
- Read latency is 1 cycle. `rd_valid` and data are registered, and `rd_valid` follows a qualified `rd_en` by exactly one clock.
- Throughput is one sample per cycle. With a prompt `frame_done`, back-to-back frames sustain `in_ready` continuously.
- A read in the same cycle as `frame_done` returns old-bank data on the next cycle.

## Structure
- `fft_pkg` holds the shared definitions:
  - constants `N_LOG2`, `N`, `DATA_W`;
  - a `bitrev` function of width N_LOG2;
  - a complex-sample typedef {re, im}.
- One sub-module, `fft_buf_ram`: a simple dual-port RAM, 512×(2·DATA_W), with a synchronous registered read and one write port. It must infer block RAM.
- Control (bank flags, counters, handshake) is in the top level.

## Test plan
- Reset, then stream samples with value re=k, im=−k for k = 0..255 → `frame_valid` rises after the last accept. Reading `rd_addr` a returns re=bitrev(a): addr 1 → 128, addr 3 → 192, addr 255 → 255.
- Fill two frames without `frame_done` → `in_ready` goes low after 512 accepts. A further `in_valid` sets `overrun` = 1 and `wr_count` stays 0.
- Hold `frame_done` until the 256th sample of frame 2 is accepted, then pulse it in that same cycle → the next cycle shows `frame_valid` = 1 on bank 1 and `in_ready` = 1.
- `rd_en` = 1 with `frame_valid` = 0 → `rd_valid` stays 0. A `frame_done` pulse while empty leaves `rd_bank` unchanged.
- Assert `rst` low after 100 accepted samples → all outputs return to reset values. The next frame restarts at `wr_count` = 0 in bank 0.
- Random `in_valid` gaps (50% duty) over 4 frames → every frame reads back exactly bit-reversed, and no `overrun` occurs while `frame_done` is prompt.
